// File: rtl/mult_periph_core.sv
// -----------------------------------------------------------------------------
// mult_periph_core
//   Memory-mapped sequential shift-add multiplier. A simple single-cycle
//   register port feeds operand, control and status registers. The engine
//   processes one multiplier bit per clock and then applies the result sign.
//
//   Register map (word offsets, bits [1:0] of the offset are ignored):
//     0x0 CTRL/STATUS  W: bit0 soft reset, bit1 start   R: {29'b0, err, busy, rdy}
//     0x4 A            low WIDTH bits stored
//     0x8 B            low WIDTH bits stored
//     0xC P            product, sign/zero extended to 32 bits, read-only
//     0x10 IRQ         {30'b0, irq_pend, irq_mask}  (only with SEQ_MULT_IRQ_EN)
//
//   Handshake: register port has no backpressure. A write is taken on every
//   clock where wr_en is high. A read is taken on every clock where rd_en is
//   high; rd_data/rd_valid are presented on the following cycle, and reflect
//   register contents from before any write in the same cycle.
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     wr_en/wr_off/wr_data register write port
//     rd_en/rd_off        register read request
//     rd_data/rd_valid    read response, one cycle after rd_en
//     rdy                 result valid (held until start / soft reset / reset)
//     busy                engine running (RUN and FIX states)
//     o_dbg_state         current FSM state (IDLE=0, RUN=1, FIX=2, DONE=3)
//     irq                 pend & mask (only with SEQ_MULT_IRQ_EN)
//
//   Optional feature macro: SEQ_MULT_IRQ_EN adds the irq port and IRQ register;
//   the offset ports then widen to 5 bits so offset 0x10 is addressable.
// -----------------------------------------------------------------------------
module mult_periph_core #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
`ifdef SEQ_MULT_IRQ_EN
  input  logic [4:0]  wr_off,
`else
  input  logic [3:0]  wr_off,
`endif
  input  logic [31:0] wr_data,
  input  logic        rd_en,
`ifdef SEQ_MULT_IRQ_EN
  input  logic [4:0]  rd_off,
`else
  input  logic [3:0]  rd_off,
`endif
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rdy,
  output logic        busy,
`ifdef SEQ_MULT_IRQ_EN
  output logic        irq,
`endif
  output logic [1:0]  o_dbg_state
);

`ifdef SEQ_MULT_IRQ_EN
  localparam int OW = 5;
`else
  localparam int OW = 4;
`endif
  localparam int IW = OW - 2;
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [IW-1:0] IDX_CTRL = IW'(0);
  localparam logic [IW-1:0] IDX_A    = IW'(1);
  localparam logic [IW-1:0] IDX_B    = IW'(2);
  localparam logic [IW-1:0] IDX_P    = IW'(3);
`ifdef SEQ_MULT_IRQ_EN
  localparam logic [IW-1:0] IDX_IRQ  = IW'(4);
`endif

  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P    = PW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_p;
  logic [CW-1:0]    r_cnt;
  logic             r_sign;
  logic             r_err;
  logic             r_rdy;
  logic             r_busy;
  logic             r_rd_valid;
  logic [31:0]      r_rd_data;
`ifdef SEQ_MULT_IRQ_EN
  logic             r_irq_mask;
  logic             r_irq_pend;
`endif

  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;
  logic             w_ctrl_wr;
  logic             w_soft;
  logic             w_start;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_sign;
  logic [PW-1:0]    w_fix;
  logic [31:0]      w_p_ext;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  assign w_wr_idx  = wr_off[OW-1:2];
  assign w_rd_idx  = rd_off[OW-1:2];
  assign w_ctrl_wr = wr_en && (w_wr_idx == IDX_CTRL);
  assign w_soft    = w_ctrl_wr && wr_data[0];
  // Soft reset takes priority over a start carried in the same write.
  assign w_start   = w_ctrl_wr && wr_data[1] && !wr_data[0];

  // Magnitudes of the operands. The most negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits, so no product overflow is possible.
  assign w_a_abs = (SIGNED && r_a[WIDTH-1]) ? (~r_a + ONE_W) : r_a;
  assign w_b_abs = (SIGNED && r_b[WIDTH-1]) ? (~r_b + ONE_W) : r_b;
  assign w_sign  = SIGNED ? (r_a[WIDTH-1] ^ r_b[WIDTH-1]) : 1'b0;

  assign w_fix   = r_sign ? (~r_acc + ONE_P) : r_acc;
  assign w_p_ext = SIGNED ? 32'($signed(r_p)) : 32'(r_p);

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_rd_idx)
      IDX_CTRL: w_rd_mux = {29'd0, r_err, r_busy, r_rdy};
      IDX_A:    w_rd_mux = 32'(r_a);
      IDX_B:    w_rd_mux = 32'(r_b);
      IDX_P:    w_rd_mux = w_p_ext;
`ifdef SEQ_MULT_IRQ_EN
      IDX_IRQ:  w_rd_mux = {30'd0, r_irq_pend, r_irq_mask};
`endif
      default:  w_rd_mux = 32'd0;
    endcase
  end

  // Upper data bits and the byte-lane offset bits carry no meaning here.
  assign w_unused = ^{wr_data, wr_off[1:0], rd_off[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_mplier   <= '0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_p        <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_err      <= 1'b0;
      r_rdy      <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
`ifdef SEQ_MULT_IRQ_EN
      r_irq_mask <= 1'b0;
      r_irq_pend <= 1'b0;
`endif
    end else begin
      // Read path samples the pre-write register values.
      r_rd_valid <= rd_en;
      r_rd_data  <= rd_en ? w_rd_mux : 32'd0;

      // Operand registers are always writable; a running job uses its copies.
      if (wr_en && (w_wr_idx == IDX_A)) r_a <= wr_data[WIDTH-1:0];
      if (wr_en && (w_wr_idx == IDX_B)) r_b <= wr_data[WIDTH-1:0];

`ifdef SEQ_MULT_IRQ_EN
      if (wr_en && (w_wr_idx == IDX_IRQ)) begin
        r_irq_mask <= wr_data[0];
        if (wr_data[1]) r_irq_pend <= 1'b0;
      end
      // Placed after the clear so a same-cycle set wins.
      if (!w_soft && (r_state == S_FIX)) r_irq_pend <= 1'b1;
      if (w_soft) begin
        r_irq_mask <= 1'b0;
        r_irq_pend <= 1'b0;
      end
`endif

      if (w_soft) begin
        r_state <= S_IDLE;
        r_p     <= '0;
        r_rdy   <= 1'b0;
        r_err   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        if (w_start && r_busy) r_err <= 1'b1;
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_start) begin
              r_mcand  <= {{WIDTH{1'b0}}, w_a_abs};
              r_mplier <= w_b_abs;
              r_sign   <= w_sign;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_rdy    <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= S_RUN;
            end
          end
          S_RUN: begin
            // Multiplicand is pre-shifted each cycle, equivalent to shifting by count.
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) r_state <= S_FIX;
          end
          S_FIX: begin
            r_p     <= w_fix;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign rdy         = r_rdy;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;
`ifdef SEQ_MULT_IRQ_EN
  assign irq         = r_irq_pend & r_irq_mask;
`endif

endmodule

// File: tb/tb_mult_periph_core.sv
// -----------------------------------------------------------------------------
// tb_mult_periph_core
//   Drives one signed (SIGNED=1) and one unsigned (SIGNED=0) WIDTH=8 instance
//   from the same register bus and checks both against expected values.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mult_periph_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_off;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_off;

  logic [31:0] rd_data_s, rd_data_u;
  logic        rd_valid_s, rd_valid_u;
  logic        rdy_s, rdy_u, busy_s, busy_u;
  logic [1:0]  dbg_s, dbg_u;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] ps;
    logic [31:0] pu;
  } vec_t;
  vec_t tbl[7];

  mult_periph_core #(.WIDTH(8), .SIGNED(1'b1)) u_s (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_off(wr_off), .wr_data(wr_data),
    .rd_en(rd_en), .rd_off(rd_off),
    .rd_data(rd_data_s), .rd_valid(rd_valid_s),
    .rdy(rdy_s), .busy(busy_s), .o_dbg_state(dbg_s)
  );

  mult_periph_core #(.WIDTH(8), .SIGNED(1'b0)) u_u (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_off(wr_off), .wr_data(wr_data),
    .rd_en(rd_en), .rd_off(rd_off),
    .rd_data(rd_data_u), .rd_valid(rd_valid_u),
    .rdy(rdy_u), .busy(busy_u), .o_dbg_state(dbg_u)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_p(input int a, input int b, input bit sgn);
    int x;
    int y;
    x = a;
    y = b;
    if (sgn) begin
      if (x >= 128) x = x - 256;
      if (y >= 128) y = y - 256;
    end
    return 32'(x * y);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [3:0] off, input logic [31:0] data);
    wr_en = 1'b1; wr_off = off; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input logic [3:0] off, input logic [31:0] es,
                          input logic [31:0] eu, input string name);
    exp_q.push_back(es);
    exp_q.push_back(eu);
    rd_en = 1'b1; rd_off = off;
    @(negedge clk);
    rd_en = 1'b0;
    check({name, "_valid"}, 32'(rd_valid_s & rd_valid_u), 32'd1);
    check({name, "_s"}, rd_data_s, exp_q.pop_front());
    check({name, "_u"}, rd_data_u, exp_q.pop_front());
  endtask

  task automatic wait_rdy(input int budget, input string name);
    int k;
    k = 0;
    while (!rdy_s && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(rdy_s & rdy_u), 32'd1);
  endtask

  // Full operation with exact latency and busy-length checks.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [31:0] ps, input logic [31:0] pu, input string name);
    int cyc;
    int busy_n;
    reg_write(4'h4, 32'(a));
    reg_write(4'h8, 32'(b));
    reg_write(4'h0, 32'h2);
    cyc = 1;
    busy_n = 0;
    while (!rdy_s && cyc < 40) begin
      if (busy_s) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'd10);
    check({name, "_busy_cycles"}, 32'(busy_n), 32'd9);
    check({name, "_rdy_u"}, 32'(rdy_u), 32'd1);
    read_chk(4'hC, ps, pu, {name, "_P"});
    read_chk(4'h0, 32'h1, 32'h1, {name, "_status"});
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    bit         seen;

    tbl[0] = '{8'h07, 8'h06, 32'h0000002A, 32'h0000002A};
    tbl[1] = '{8'hFD, 8'h05, 32'hFFFFFFF1, 32'h000004F1};
    tbl[2] = '{8'h80, 8'h80, 32'h00004000, 32'h00004000};
    tbl[3] = '{8'hFF, 8'hFF, 32'h00000001, 32'h0000FE01};
    tbl[4] = '{8'h00, 8'h80, 32'h00000000, 32'h00000000};
    tbl[5] = '{8'h7F, 8'h80, 32'hFFFFC080, 32'h00003F80};
    tbl[6] = '{8'h01, 8'hFF, 32'hFFFFFFFF, 32'h000000FF};

    reset = 1'b1; wr_en = 1'b0; wr_off = '0; wr_data = '0; rd_en = 1'b0; rd_off = '0;
    idle(3);
    reset = 1'b0;

    // Reset state
    check("reset_rdy", 32'(rdy_s | rdy_u), 32'd0);
    check("reset_busy", 32'(busy_s | busy_u), 32'd0);
    check("reset_rd_valid", 32'(rd_valid_s | rd_valid_u), 32'd0);
    check("reset_rd_data", rd_data_s | rd_data_u, 32'd0);
    read_chk(4'h0, 32'h0, 32'h0, "reset_status");
    read_chk(4'h4, 32'h0, 32'h0, "reset_A");
    read_chk(4'h8, 32'h0, 32'h0, "reset_B");
    read_chk(4'hC, 32'h0, 32'h0, "reset_P");

    // Register-port corners: same-cycle write/read, ignored low offset bits,
    // upper data bits dropped, P is read-only.
    reg_write(4'h4, 32'h11);
    rd_en = 1'b1; rd_off = 4'h4;
    wr_en = 1'b1; wr_off = 4'h4; wr_data = 32'h22;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    check("wr_rd_same_old", rd_data_s, 32'h11);
    read_chk(4'h4, 32'h22, 32'h22, "wr_rd_same_new");
    reg_write(4'h6, 32'h1FD);
    read_chk(4'h4, 32'hFD, 32'hFD, "off_lowbits_trunc");
    reg_write(4'hC, 32'h1234);
    read_chk(4'hC, 32'h0, 32'h0, "P_readonly");

    // Table-driven products
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].ps, tbl[i].pu, $sformatf("tbl%0d", i));
    end

    // P read while busy returns previous product
    reg_write(4'h4, 32'h5);
    reg_write(4'h8, 32'h5);
    reg_write(4'h0, 32'h2);
    check("busy_after_start", 32'(busy_s & busy_u), 32'd1);
    read_chk(4'hC, tbl[6].ps, tbl[6].pu, "P_while_busy");
    wait_rdy(20, "P_while_busy_rdy");
    read_chk(4'hC, 32'd25, 32'd25, "P_after_busy");

    // Start while busy: sticky err, running job keeps its latched operands
    reg_write(4'h4, 32'h3);
    reg_write(4'h8, 32'h5);
    reg_write(4'h0, 32'h2);
    idle(2);
    reg_write(4'h0, 32'h2);
    reg_write(4'h4, 32'h9);
    wait_rdy(20, "err_rdy");
    read_chk(4'h0, 32'h5, 32'h5, "err_status");
    read_chk(4'hC, 32'd15, 32'd15, "err_P_old_ops");
    reg_write(4'h0, 32'h2);
    wait_rdy(20, "err_second_rdy");
    read_chk(4'hC, 32'd45, 32'd45, "err_second_P");
    read_chk(4'h0, 32'h5, 32'h5, "err_sticky");

    // Soft reset (with start) mid-operation
    reg_write(4'h0, 32'h2);
    idle(2);
    reg_write(4'h0, 32'h3);
    check("soft_busy", 32'(busy_s | busy_u), 32'd0);
    check("soft_rdy", 32'(rdy_s | rdy_u), 32'd0);
    read_chk(4'h0, 32'h0, 32'h0, "soft_status");
    read_chk(4'hC, 32'h0, 32'h0, "soft_P");
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rdy_s || rdy_u || busy_s || busy_u) seen = 1'b1;
    end
    check("soft_no_rdy", 32'(seen), 32'd0);
    read_chk(4'h4, 32'h9, 32'h9, "soft_A_kept");

    // Random products against the model
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, ref_p(int'(ra), int'(rb), 1'b1), ref_p(int'(ra), int'(rb), 1'b0),
             $sformatf("rnd%0d_%02h_%02h", i, ra, rb));
    end

    // Hard reset mid-operation
    reg_write(4'h4, 32'h4);
    reg_write(4'h8, 32'h4);
    reg_write(4'h0, 32'h2);
    idle(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 32'(busy_s | busy_u), 32'd0);
    check("rst_mid_rdy", 32'(rdy_s | rdy_u), 32'd0);
    read_chk(4'h0, 32'h0, 32'h0, "rst_mid_status");
    read_chk(4'h4, 32'h0, 32'h0, "rst_mid_A");
    read_chk(4'hC, 32'h0, 32'h0, "rst_mid_P");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
